transmitter: RTL and testbench
==============================

Name: transmitter

Overview:
UART transmitter that pairs with the autobaud receiver.
- Pulls bytes from a FIFO read interface and serialises them onto TX_PIN as 8N1 frames, or 8 data bits plus STOP_BITS stop bits.
- Bit timing comes from the CPB value the receiver measures during autobaud, so the TX baud rate matches the host automatically.
- Sits between the outbound FIFO and the physical TX pin of the uart_transport block.

Parameters:
CPB_WIDTH, 12, width of the clocks-per-bit input; must equal the receiver's CPB_WIDTH.
STOP_BITS, 1, number of stop bits per frame; legal values are 1 and 2.

Ports:
CLK  input  1  clock.
RESETn  input  1  synchronous, active-low reset.
CPB  input  CPB_WIDTH  clocks per bit, from the receiver; 0 means baud rate not yet known.
RDDATA  input  8  FIFO read data; valid the cycle after RDEN.
RDEN  output  1  FIFO read strobe; one-cycle pulse.
RDEMPTY  input  1  FIFO empty flag.
TX_PIN  output  1  serial output; idle high.
BUSY  output  1  high from the RDEN cycle until the end of the last stop bit.

Behaviour:
- Reset (RESETn low at a CLK edge): next cycle TX_PIN=1, RDEN=0, BUSY=0, state=IDLE, all counters 0. This applies mid-frame too: the frame is abandoned and the line returns high immediately. The byte already read from the FIFO is lost.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - TX_PIN=1.
  - If CPB!=0 and RDEMPTY==0: assert RDEN for exactly one cycle, set BUSY=1, go to FETCH.
  - If CPB==0: never read, even if the FIFO is non-empty.
- FETCH:
  - RDEN=0.
  - Capture RDDATA into the shift register.
  - Latch CPB into an internal cpb_l, used for the whole frame. CPB changes mid-frame have no effect until the next frame.
  - Clear the bit-timer, go to START.
- START: TX_PIN=0 for exactly cpb_l cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held exactly cpb_l cycles.
  - Shift right at each bit boundary; a 3-bit bit counter runs 0..7, and DATA→STOP on the boundary where the counter = 7.
- STOP:
  - TX_PIN=1 for STOP_BITS*cpb_l cycles.
  - Then IDLE, with BUSY=0 in the IDLE cycle.
- Bit timer:
  - Counts 0..cpb_l-1; the boundary is at count==cpb_l-1.
  - cpb_l=1 is legal and gives 1 cycle per bit.
  - Counter width is CPB_WIDTH; there is no overflow, because the compare uses cpb_l-1 and cpb_l>=1 is guaranteed by FETCH entry.
- Latency: RDEN in cycle N → FETCH in N+1 → TX_PIN falls at N+2.
- Frame length from RDEN to return to IDLE: 2 + (9+STOP_BITS)*cpb_l cycles.
- Back-to-back: the minimum inter-frame gap is 2 extra idle-high cycles after the stop bits (IDLE + FETCH).
- RDEN is never asserted while RDEMPTY=1 or while in any state other than IDLE.
- TX_PIN is driven from a register (glitch-free): one register, updated on state/bit boundaries.

Decomposition:
- Package uart_pkg holds:
  - typedef tx_state_t (enum logic [2:0]: IDLE, FETCH, START, DATA, STOP);
  - localparam DATA_BITS=8.
- Natural sub-module: baud_tick.
  - Inputs: CLK, RESETn, clear, cpb_l.
  - Output: tick, asserted on the last cycle of each bit period.
  - Reusable by the receiver in a later refactor.
- The FSM, shift register and bit counter stay in transmitter.

Test Plan:
1. Basic frame: CPB=4, FIFO holds 0xA5, STOP_BITS=1.
   - Expect RDEN pulse at cycle N and TX_PIN falling at N+2.
   - Expect TX_PIN bits start 0, then 1,0,1,0,0,1,0,1, then stop 1, each exactly 4 cycles.
   - Expect BUSY low at N+2+40.
2. CPB gating: CPB=0, FIFO non-empty for 100 cycles.
   - Expect no RDEN and TX_PIN=1 throughout.
   - Set CPB=3: RDEN on the next cycle, frame 0 timing at 3 cycles/bit.
3. Back-to-back: CPB=2, FIFO holds 0x00 then 0xFF.
   - Expect two frames of 20 cycles each, separated by exactly 2 high cycles.
   - Expect exactly two RDEN pulses.
4. CPB change mid-frame: start 0x55 with CPB=8, change CPB to 4 during DATA.
   - Current frame stays at 8 cycles/bit.
   - Next frame runs at 4 cycles/bit.
5. Reset mid-frame: assert RESETn=0 during DATA bit 3.
   - Next cycle TX_PIN=1, BUSY=0, RDEN=0.
   - After release, with a non-empty FIFO, a fresh frame begins with the correct latency.
6. Edge timing: CPB=1, STOP_BITS=2, byte 0x80.
   - Expect 11-cycle serial frame: 0,0,0,0,0,0,0,0,1,1,1.
   - Expect BUSY high for 13 cycles total.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transport blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/transmitter_if.sv
// FIFO read port between the outbound FIFO (slave) and the transmitter (master).
interface transmitter_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] RDDATA;
    logic                 RDEN;
    logic                 RDEMPTY;

    modport master (input RDDATA, input RDEMPTY, output RDEN);
    modport slave  (output RDDATA, output RDEMPTY, input RDEN);

endinterface

// File: rtl/transmitter_baud_tick.sv
// Bit-period timer: tick marks the last cycle of each cpb_l-cycle bit period.
module baud_tick #(
    parameter int CPB_WIDTH = 12
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 clear,
    input  logic [CPB_WIDTH-1:0] cpb_l,
    output logic                 tick
);

    logic [CPB_WIDTH-1:0] cnt;

    // cpb_l >= 1 whenever the timer runs, so cpb_l-1 never wraps in use
    assign tick = !clear && (cnt == cpb_l - 1'b1);

    always_ff @(posedge CLK) begin
        if (!RESETn || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: pulls bytes from a FIFO and sends 8-data-bit frames at the
// autobaud-measured CPB rate, with STOP_BITS stop bits.
module transmitter
    import uart_pkg::*;
#(
    parameter int CPB_WIDTH = 12,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [CPB_WIDTH-1:0] CPB,
    transmitter_if.master        fifo,
    output logic                 TX_PIN,
    output logic                 BUSY
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t              state, state_n;
    logic [CPB_WIDTH-1:0]   cpb_l;
    logic [DATA_BITS-1:0]   shreg;
    logic [2:0]             bit_cnt;
    logic                   tick;
    logic                   tmr_clr;
    logic                   rd_go;

    // Gated by RESETn so no byte is popped while reset is being held
    assign rd_go     = RESETn && (state == IDLE) && (CPB != '0) && !fifo.RDEMPTY;
    assign fifo.RDEN = rd_go;
    assign BUSY      = rd_go || (state != IDLE);
    assign tmr_clr   = (state == IDLE) || (state == FETCH);

    baud_tick #(.CPB_WIDTH(CPB_WIDTH)) u_baud_tick (
        .CLK    (CLK),
        .RESETn (RESETn),
        .clear  (tmr_clr),
        .cpb_l  (cpb_l),
        .tick   (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rd_go) state_n = FETCH;
            FETCH:   state_n = START;
            START:   if (tick) state_n = DATA;
            DATA:    if (tick && bit_cnt == LAST_BIT) state_n = STOP;
            STOP:    if (tick && bit_cnt == STOP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // TX_PIN is registered and only changes at bit boundaries
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            TX_PIN  <= 1'b1;
            cpb_l   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    shreg   <= fifo.RDDATA;
                    cpb_l   <= CPB;
                    bit_cnt <= '0;
                    TX_PIN  <= 1'b0;
                end
                START: begin
                    if (tick) TX_PIN <= shreg[0];
                end
                DATA: begin
                    if (tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            TX_PIN <= 1'b1;
                        end else begin
                            TX_PIN <= shreg[1];
                            shreg  <= shreg >> 1;
                        end
                    end
                end
                STOP: begin
                    if (tick)
                        bit_cnt <= (bit_cnt == STOP_LAST) ? 3'd0 : bit_cnt + 1'b1;
                end
                default: TX_PIN <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench: two transmitters (1 and 2 stop bits) fed identical stimulus,
// each compared every cycle against a frame-level waveform model.
module tb_transmitter;
    import uart_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [11:0] CPB;
    logic        tx0, tx1, busy0, busy1;

    always #5 CLK = ~CLK;

    transmitter_if f0();
    transmitter_if f1();

    transmitter #(.CPB_WIDTH(12), .STOP_BITS(1)) dut0 (
        .CLK(CLK), .RESETn(RESETn), .CPB(CPB), .fifo(f0.master), .TX_PIN(tx0), .BUSY(busy0)
    );
    transmitter #(.CPB_WIDTH(12), .STOP_BITS(2)) dut1 (
        .CLK(CLK), .RESETn(RESETn), .CPB(CPB), .fifo(f1.master), .TX_PIN(tx1), .BUSY(busy1)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         chk_en = 0;
    logic [7:0] fifo_q [2][$];
    bit         exp_q  [2][$];
    bit         pend   [2];
    logic [7:0] pend_d [2];
    int         sb     [2];
    int         rden_cnt [2];
    int         busy_cnt [2];
    logic       rden_now [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q[0].push_back(b);
        fifo_q[1].push_back(b);
        f0.RDEMPTY = 1'b0;
        f1.RDEMPTY = 1'b0;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            rden_cnt[i] = 0;
            busy_cnt[i] = 0;
        end
    endtask

    // One clock: predict and compare at negedge, advance, then play the FIFO side
    task automatic cycle();
        logic r, t, b, et, eb, er, rst_edge;
        int   c;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            r = (i == 0) ? f0.RDEN : f1.RDEN;
            t = (i == 0) ? tx0 : tx1;
            b = (i == 0) ? busy0 : busy1;
            er = 1'b0;
            if (pend[i]) begin
                // fetch cycle: line high, frame timing fixed by CPB seen now
                et = 1'b1; eb = 1'b1;
                c = int'(CPB);
                repeat (c) exp_q[i].push_back(1'b0);
                for (int k = 0; k < 8; k++) repeat (c) exp_q[i].push_back(pend_d[i][k]);
                repeat (sb[i] * c) exp_q[i].push_back(1'b1);
                pend[i] = 1'b0;
            end else if (exp_q[i].size() > 0) begin
                et = exp_q[i].pop_front(); eb = 1'b1;
            end else begin
                et = 1'b1;
                er = RESETn && (CPB != 12'd0) && (fifo_q[i].size() > 0);
                eb = er;
                if (er) begin
                    pend[i]   = 1'b1;
                    pend_d[i] = fifo_q[i][0];
                end
            end
            if (chk_en) begin
                check($sformatf("rden%0d", i), 32'(r), 32'(er));
                check($sformatf("tx%0d", i),   32'(t), 32'(et));
                check($sformatf("busy%0d", i), 32'(b), 32'(eb));
            end
            rden_now[i] = r;
            if (r === 1'b1) rden_cnt[i]++;
            if (b === 1'b1) busy_cnt[i]++;
        end
        rst_edge = RESETn;
        @(posedge CLK);
        if (!rst_edge) begin
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                pend[i] = 1'b0;
            end
        end
        #1;
        if (rden_now[0] === 1'b1 && fifo_q[0].size() > 0) f0.RDDATA = fifo_q[0].pop_front();
        if (rden_now[1] === 1'b1 && fifo_q[1].size() > 0) f1.RDDATA = fifo_q[1].pop_front();
        f0.RDEMPTY = (fifo_q[0].size() == 0);
        f1.RDEMPTY = (fifo_q[1].size() == 0);
    endtask

    task automatic run_idle(input string tag, input int limit);
        bit done = 0;
        for (int n = 0; n < limit && !done; n++) begin
            cycle();
            done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && !pend[0] && !pend[1]
                && (fifo_q[0].size() == 0) && (fifo_q[1].size() == 0)
                && !rden_now[0] && !rden_now[1];
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_rden(input string tag, input int limit);
        bit seen = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            cycle();
            seen = (rden_now[0] === 1'b1);
        end
        check({tag, "_rden_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int c;
        sb[0] = 1; sb[1] = 2;
        pend[0] = 0; pend[1] = 0;
        clr_counts();
        RESETn = 1'b0;
        CPB = 12'd0;
        f0.RDDATA = 8'h00; f1.RDDATA = 8'h00;
        f0.RDEMPTY = 1'b1; f1.RDEMPTY = 1'b1;
        repeat (2) cycle();
        chk_en = 1;
        cycle();
        check("reset_tx0", 32'(tx0), 32'd1);
        check("reset_busy1", 32'(busy1), 32'd0);
        RESETn = 1'b1;

        // 1: basic frame 0xA5 at 4 clocks/bit
        CPB = 12'd4;
        clr_counts();
        push(8'hA5);
        run_idle("t1", 200);
        check("t1_busy0", 32'(busy_cnt[0]), 32'd42);
        check("t1_busy1", 32'(busy_cnt[1]), 32'd46);
        check("t1_rden0", 32'(rden_cnt[0]), 32'd1);

        // 2: CPB=0 holds off reads even with data waiting
        CPB = 12'd0;
        clr_counts();
        push(8'($urandom));
        repeat (100) cycle();
        check("t2_norden", 32'(rden_cnt[0] + rden_cnt[1]), 32'd0);
        check("t2_tx_idle", 32'(tx0 & tx1), 32'd1);
        CPB = 12'd3;
        run_idle("t2", 200);
        check("t2_rden", 32'(rden_cnt[0]), 32'd1);

        // 3: back-to-back 0x00, 0xFF at 2 clocks/bit
        CPB = 12'd2;
        clr_counts();
        push(8'h00);
        push(8'hFF);
        run_idle("t3", 200);
        check("t3_rden0", 32'(rden_cnt[0]), 32'd2);
        check("t3_rden1", 32'(rden_cnt[1]), 32'd2);
        check("t3_busy0", 32'(busy_cnt[0]), 32'd44);

        // 4: CPB change during DATA only affects the following frame
        CPB = 12'd8;
        clr_counts();
        push(8'h55);
        push(8'($urandom));
        wait_rden("t4", 50);
        repeat (1 + 8 + 8 * 2) cycle();
        CPB = 12'd4;
        run_idle("t4", 1000);
        check("t4_rden0", 32'(rden_cnt[0]), 32'd2);

        // 5: reset during data bit 3, then a fresh frame
        c = int'($urandom_range(2, 5));
        CPB = 12'(c);
        push(8'($urandom));
        push(8'($urandom));
        push(8'($urandom));
        wait_rden("t5", 50);
        repeat (1 + 4 * c + 1) cycle();
        RESETn = 1'b0;
        cycle();
        check("t5_tx0", 32'(tx0), 32'd1);
        check("t5_busy0", 32'(busy0), 32'd0);
        check("t5_rden0", 32'(f0.RDEN), 32'd0);
        check("t5_tx1", 32'(tx1), 32'd1);
        cycle();
        RESETn = 1'b1;
        clr_counts();
        run_idle("t5", 500);
        check("t5_rden_after", 32'(rden_cnt[0]), 32'd2);

        // 6: CPB=1, 0x80, two stop bits on dut1
        CPB = 12'd1;
        clr_counts();
        push(8'h80);
        run_idle("t6", 100);
        check("t6_busy1", 32'(busy_cnt[1]), 32'd13);
        check("t6_busy0", 32'(busy_cnt[0]), 32'd12);

        // random frames with random rates and occasional FIFO refill gaps
        for (int f = 0; f < 8; f++) begin
            CPB = 12'($urandom_range(1, 6));
            push(8'($urandom));
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            repeat ($urandom_range(0, 3)) cycle();
            run_idle("rnd", 600);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
